// File: rtl/bram_read.sv
// +----------------------------------------------------------------------------+
// | Module      : bram_read                                                    |
// | Description : Read side of the zxram BRAM port. Accepts single-doubleword  |
// |               read requests, issues one-cycle BRAM read strobes, returns   |
// |               the 64-bit word with a cvalid pulse, and keeps a one-entry   |
// |               line buffer that is invalidated by snooping the write path.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module bram_read #(
  parameter int READ_LATENCY = 1   // BRAM sampling edge to valid bram_dout, 1..4
) (
  input  logic        clk_memory,
  input  logic        aresetn,
  output logic [12:0] bram_addr,
  output logic        bram_clk,
  output logic        bram_rst,
  output logic [63:0] bram_din,
  input  logic [63:0] bram_dout,
  output logic        bram_en,
  output logic        bram_we,
  input  logic [17:0] addr,
  input  logic        rd_req,
  output logic [63:0] cache,
  output logic        cvalid,
  output logic        busy,
  input  logic [17:0] wr_addr,
  input  logic        wr_strobe
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Counter preload for the WAIT phase; WAIT lasts READ_LATENCY-1 cycles.
  localparam logic [2:0] c_CNT_INIT = 3'(READ_LATENCY - 1);

  state_t      r_state;
  state_t      w_state_next;

  logic [12:0] r_bram_addr;
  logic        r_bram_en;
  logic [63:0] r_cache;
  logic        r_cvalid;
  logic        r_busy;
  logic [2:0]  r_cnt;
  logic [16:0] r_tag;          // tag of the access in flight
  logic        r_poison;       // in-flight line was written during the fetch
  logic [16:0] r_line_tag;
  logic [63:0] r_line_data;
  logic        r_line_valid;

  // The ports carry address bits [20:3]; bit 0 here is address bit 3,
  // which only selects within the doubleword pair and is not needed.
  logic [16:0] w_req_tag;
  logic [16:0] w_snoop_tag;
  logic        w_snoop_line;   // write hits the buffered line
  logic        w_snoop_req;    // write hits the address being requested
  logic        w_snoop_fly;    // write hits the line currently being fetched
  logic        w_hit;
  logic        w_miss;
  logic        w_unused_ok;

  assign w_req_tag   = addr[17:1];
  assign w_snoop_tag = wr_addr[17:1];

  assign w_snoop_line = wr_strobe & (w_snoop_tag == r_line_tag);
  assign w_snoop_req  = wr_strobe & (w_snoop_tag == w_req_tag);
  assign w_snoop_fly  = wr_strobe & (w_snoop_tag == r_tag);

  // A write to the buffered line in the same cycle demotes a hit to a miss.
  assign w_hit  = rd_req & r_line_valid & (w_req_tag == r_line_tag) & ~w_snoop_line;
  assign w_miss = rd_req & ~w_hit;

  assign w_unused_ok = &{1'b0, addr[0], wr_addr[0]};

  assign bram_clk  = clk_memory;
  assign bram_rst  = ~aresetn;
  assign bram_din  = 64'd0;
  assign bram_we   = 1'b0;
  assign bram_addr = r_bram_addr;
  assign bram_en   = r_bram_en;
  assign cache     = r_cache;
  assign cvalid    = r_cvalid;
  assign busy      = r_busy;

  // State register.
  always_ff @(posedge clk_memory or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: miss starts a fetch, latency selects the WAIT detour.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (READ_LATENCY == 1) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt <= 3'd1) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: BRAM strobe, latency counter, result capture and line buffer.
  always_ff @(posedge clk_memory or negedge aresetn) begin
    if (!aresetn) begin
      r_bram_addr  <= 13'd0;
      r_bram_en    <= 1'b0;
      r_cache      <= 64'd0;
      r_cvalid     <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt        <= 3'd0;
      r_tag        <= 17'd0;
      r_poison     <= 1'b0;
      r_line_tag   <= 17'd0;
      r_line_data  <= 64'd0;
      r_line_valid <= 1'b0;
    end else begin
      r_cvalid <= 1'b0;
      if (w_snoop_line) begin
        r_line_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_cache  <= r_line_data;
            r_cvalid <= 1'b1;
          end else if (w_miss) begin
            r_tag       <= w_req_tag;
            r_bram_addr <= addr[13:1];
            r_bram_en   <= 1'b1;
            r_busy      <= 1'b1;
            // A write landing on the same edge as acceptance already
            // makes the fetched copy stale for buffering purposes.
            r_poison    <= w_snoop_req;
          end
        end
        S_ISSUE: begin
          r_bram_en <= 1'b0;
          r_cnt     <= c_CNT_INIT;
          if (w_snoop_fly) begin
            r_poison <= 1'b1;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (w_snoop_fly) begin
            r_poison <= 1'b1;
          end
        end
        S_DONE: begin
          r_cache  <= bram_dout;
          r_cvalid <= 1'b1;
          r_busy   <= 1'b0;
          if (r_poison | w_snoop_fly) begin
            r_line_valid <= 1'b0;
          end else begin
            r_line_tag   <= r_tag;
            r_line_data  <= bram_dout;
            r_line_valid <= 1'b1;
          end
        end
        default: begin
          r_bram_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bram_read.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_bram_read                                                 |
// | Description : Directed bench for bram_read with two instances, one at      |
// |               READ_LATENCY=1 and one at READ_LATENCY=3.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bram_read;

  localparam logic [63:0] c_D1 = 64'hDEADBEEF_01234567;
  localparam logic [63:0] c_D2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] c_D3 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] c_D4 = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [63:0] c_D5 = 64'hCAFE_F00D_8BAD_F00D;
  localparam logic [63:0] c_D6 = 64'h0000_FFFF_1234_5678;
  localparam logic [63:0] c_D7 = 64'h7777_8888_9999_AAAA;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [17:0] addr = 18'd0;
  logic [63:0] bram_dout = 64'd0;
  logic [17:0] wr_addr = 18'd0;
  logic        wr_strobe = 1'b0;
  logic        rd_req1 = 1'b0;
  logic        rd_req3 = 1'b0;

  logic [12:0] b_addr1, b_addr3;
  logic        b_clk1, b_clk3;
  logic        b_rst1, b_rst3;
  logic [63:0] b_din1, b_din3;
  logic        b_en1, b_en3;
  logic        b_we1, b_we3;
  logic [63:0] cache1, cache3;
  logic        cvalid1, cvalid3;
  logic        busy1, busy3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_read #(.READ_LATENCY(1)) u_dut1 (
    .clk_memory(clk), .aresetn(aresetn),
    .bram_addr(b_addr1), .bram_clk(b_clk1), .bram_rst(b_rst1),
    .bram_din(b_din1), .bram_dout(bram_dout), .bram_en(b_en1), .bram_we(b_we1),
    .addr(addr), .rd_req(rd_req1), .cache(cache1), .cvalid(cvalid1), .busy(busy1),
    .wr_addr(wr_addr), .wr_strobe(wr_strobe)
  );

  bram_read #(.READ_LATENCY(3)) u_dut3 (
    .clk_memory(clk), .aresetn(aresetn),
    .bram_addr(b_addr3), .bram_clk(b_clk3), .bram_rst(b_rst3),
    .bram_din(b_din3), .bram_dout(bram_dout), .bram_en(b_en3), .bram_we(b_we3),
    .addr(addr), .rd_req(rd_req3), .cache(cache3), .cvalid(cvalid3), .busy(busy3),
    .wr_addr(wr_addr), .wr_strobe(wr_strobe)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_en1",     64'(b_en1),   64'd0);
    check("rst_addr1",   64'(b_addr1), 64'd0);
    check("rst_cache1",  cache1,       64'd0);
    check("rst_cvalid1", 64'(cvalid1), 64'd0);
    check("rst_busy1",   64'(busy1),   64'd0);
    check("rst_bramrst", 64'(b_rst1),  64'd1);
    check("rst_busy3",   64'(busy3),   64'd0);
    check("tie_we",      64'(b_we1),   64'd0);
    check("tie_din",     b_din3,       64'd0);
    aresetn = 1'b1;
    tick();
    check("run_bramrst", 64'(b_rst1),  64'd0);

    // ---------------- miss, latency 1 ----------------
    addr = 18'h00010; bram_dout = c_D1; rd_req1 = 1'b1;
    tick();                                   // E0
    rd_req1 = 1'b0;
    check("m1_en_e0",   64'(b_en1),   64'd1);
    check("m1_addr_e0", 64'(b_addr1), 64'h8);
    check("m1_busy_e0", 64'(busy1),   64'd1);
    check("m1_cv_e0",   64'(cvalid1), 64'd0);
    tick();                                   // E1
    check("m1_en_e1",   64'(b_en1),   64'd0);
    check("m1_busy_e1", 64'(busy1),   64'd1);
    check("m1_cv_e1",   64'(cvalid1), 64'd0);
    tick();                                   // E2
    check("m1_cv_e2",   64'(cvalid1), 64'd1);
    check("m1_data_e2", cache1,       c_D1);
    check("m1_busy_e2", 64'(busy1),   64'd0);
    tick();                                   // E3
    check("m1_cv_e3",   64'(cvalid1), 64'd0);
    check("m1_hold_e3", cache1,       c_D1);
    check("m1_ahold",   64'(b_addr1), 64'h8);

    // ---------------- hit, latency 1 ----------------
    bram_dout = c_D2; rd_req1 = 1'b1;
    tick();
    rd_req1 = 1'b0;
    check("hit_cv",   64'(cvalid1), 64'd1);
    check("hit_data", cache1,       c_D1);
    check("hit_en",   64'(b_en1),   64'd0);
    check("hit_busy", 64'(busy1),   64'd0);
    tick();
    check("hit_cv_off", 64'(cvalid1), 64'd0);

    // ---------------- miss, latency 3, requests while busy ----------------
    addr = 18'h00010; bram_dout = c_D3; rd_req3 = 1'b1;
    tick();                                   // E0
    check("m3_en_e0",   64'(b_en3),   64'd1);
    check("m3_addr_e0", 64'(b_addr3), 64'h8);
    check("m3_busy_e0", 64'(busy3),   64'd1);
    tick();                                   // E1, rd_req still high
    rd_req3 = 1'b0;
    check("m3_en_e1",   64'(b_en3),   64'd0);
    tick();                                   // E2
    check("m3_en_e2",   64'(b_en3),   64'd0);
    check("m3_cv_e2",   64'(cvalid3), 64'd0);
    rd_req3 = 1'b1;
    tick();                                   // E3, rd_req pulse while busy
    rd_req3 = 1'b0;
    check("m3_en_e3",   64'(b_en3),   64'd0);
    check("m3_busy_e3", 64'(busy3),   64'd1);
    check("m3_cv_e3",   64'(cvalid3), 64'd0);
    tick();                                   // E4
    check("m3_cv_e4",   64'(cvalid3), 64'd1);
    check("m3_data_e4", cache3,       c_D3);
    check("m3_busy_e4", 64'(busy3),   64'd0);
    tick();                                   // E5
    check("m3_cv_e5",   64'(cvalid3), 64'd0);
    check("m3_en_e5",   64'(b_en3),   64'd0);

    // ---------------- snoop invalidates buffered line ----------------
    wr_addr = 18'h00010; wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
    addr = 18'h00010; bram_dout = c_D4; rd_req1 = 1'b1;
    tick();                                   // E0
    rd_req1 = 1'b0;
    check("sn_en",    64'(b_en1),   64'd1);
    check("sn_cv",    64'(cvalid1), 64'd0);
    tick();
    tick();                                   // E2
    check("sn_cv_e2",   64'(cvalid1), 64'd1);
    check("sn_data_e2", cache1,       c_D4);

    // ---------------- snoop during WAIT poisons the fetch ----------------
    addr = 18'h00022; bram_dout = c_D5; rd_req3 = 1'b1;
    tick();                                   // E0
    rd_req3 = 1'b0;
    check("ps_en_e0",   64'(b_en3),   64'd1);
    check("ps_addr_e0", 64'(b_addr3), 64'h11);
    tick();                                   // E1 -> WAIT
    wr_addr = 18'h00022; wr_strobe = 1'b1;
    tick();                                   // E2 snoop seen in WAIT
    wr_strobe = 1'b0;
    tick();                                   // E3
    tick();                                   // E4
    check("ps_cv_e4",   64'(cvalid3), 64'd1);
    check("ps_data_e4", cache3,       c_D5);
    rd_req3 = 1'b1;
    tick();                                   // E5: re-read must miss
    rd_req3 = 1'b0; bram_dout = c_D6;
    check("ps_reread_en", 64'(b_en3),   64'd1);
    check("ps_reread_cv", 64'(cvalid3), 64'd0);
    tick();
    tick();
    tick();                                   // E8
    check("ps_busy_e8", 64'(busy3),   64'd1);
    check("ps_cv_e8",   64'(cvalid3), 64'd0);
    tick();                                   // E9
    check("ps_cv_e9",   64'(cvalid3), 64'd1);
    check("ps_data_e9", cache3,       c_D6);

    // ---------------- reset during WAIT ----------------
    rd_req3 = 1'b1;                           // 0x22 now buffered: hit
    tick();
    rd_req3 = 1'b0;
    check("pre_hit_cv",   64'(cvalid3), 64'd1);
    check("pre_hit_data", cache3,       c_D6);
    check("pre_hit_en",   64'(b_en3),   64'd0);
    addr = 18'h00030; rd_req3 = 1'b1;
    tick();                                   // E0
    rd_req3 = 1'b0;
    check("ar_en_e0", 64'(b_en3), 64'd1);
    tick();                                   // E1 -> WAIT
    aresetn = 1'b0;
    #1;
    check("ar_en",    64'(b_en3),   64'd0);
    check("ar_addr",  64'(b_addr3), 64'd0);
    check("ar_cache", cache3,       64'd0);
    check("ar_cv",    64'(cvalid3), 64'd0);
    check("ar_busy",  64'(busy3),   64'd0);
    tick();
    tick();
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ar_no_cv",   64'(cvalid3), 64'd0);
      check("ar_no_busy", 64'(busy3),   64'd0);
    end
    addr = 18'h00022; bram_dout = c_D7; rd_req3 = 1'b1;
    tick();                                   // E0: buffer lost, miss
    rd_req3 = 1'b0;
    check("ar_miss_en",   64'(b_en3),   64'd1);
    check("ar_miss_addr", 64'(b_addr3), 64'h11);
    check("ar_miss_cv",   64'(cvalid3), 64'd0);
    tick();
    tick();
    tick();
    check("ar_miss_cv_e3", 64'(cvalid3), 64'd0);
    tick();                                   // E4
    check("ar_miss_cv_e4", 64'(cvalid3), 64'd1);
    check("ar_miss_data",  cache3,       c_D7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
